// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline top and its stall/clear controller.
// The pipeline (master) drives hazard, branch and memory-response inputs.
// The controller (slave) returns per-stage stall/clear masks, the fault flag
// and the performance counters.
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int MEM_CODE_W = 2,
    parameter int CNT_W      = 16
);
    logic                  i_branch;
    logic                  i_load_hazard;
    logic                  i_mem_req_en;
    logic [MEM_CODE_W-1:0] i_mem_res_code;
    logic [NUM_STAGES-1:0] o_stall;
    logic [NUM_STAGES-1:0] o_clr;
    logic                  o_fault;
    logic [CNT_W-1:0]      o_stall_cnt;
    logic [CNT_W-1:0]      o_flush_cnt;
    logic [CNT_W-1:0]      o_wait_len;

    modport master (
        output i_branch, i_load_hazard, i_mem_req_en, i_mem_res_code,
        input  o_stall, o_clr, o_fault, o_stall_cnt, o_flush_cnt, o_wait_len
    );

    modport slave (
        input  i_branch, i_load_hazard, i_mem_req_en, i_mem_res_code,
        output o_stall, o_clr, o_fault, o_stall_cnt, o_flush_cnt, o_wait_len
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/clear controller for the in-order pipeline.
// Stage 0 is fetch. Per-stage stall/clear masks are combinational from the
// FSM state and the current hazard, branch and memory inputs. The FSM tracks
// variable-latency memory waits and a sticky fault state, which only a reset
// leaves. Performance counters saturate instead of wrapping.
module pipe_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int HAZ_STAGE   = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int ME_STAGE    = 3,
    parameter int MEM_CODE_W  = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         resetn,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    localparam logic [MEM_CODE_W-1:0] CODE_NONE = MEM_CODE_W'(2'd0);
    localparam logic [MEM_CODE_W-1:0] CODE_WAIT = MEM_CODE_W'(2'd1);
    localparam logic [MEM_CODE_W-1:0] CODE_DONE = MEM_CODE_W'(2'd2);
    localparam logic [MEM_CODE_W-1:0] CODE_ERR  = MEM_CODE_W'(2'd3);

    // Timeout is tracked on its own counter so a narrow CNT_W cannot hide it.
    localparam int               TMR_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // Build a mask with bits lo..hi set, clipped to the stage count.
    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        m = {NUM_STAGES{1'b0}};
        for (int i = 0; i < NUM_STAGES; i++) begin
            if ((i >= lo) && (i <= hi)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] ALL_ONES  = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] ALL_ZERO  = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] STALL_MEM = range_mask(0, ME_STAGE - 1);
    localparam logic [NUM_STAGES-1:0] CLR_MEM   = range_mask(ME_STAGE, ME_STAGE);
    localparam logic [NUM_STAGES-1:0] CLR_BR    = range_mask(1, FLUSH_DEPTH);
    localparam logic [NUM_STAGES-1:0] STALL_HAZ = range_mask(0, HAZ_STAGE);
    localparam logic [NUM_STAGES-1:0] CLR_HAZ   = range_mask(HAZ_STAGE + 1, HAZ_STAGE + 1);

    state_e                state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  fault_q, fault_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]      wait_len_q, wait_len_d;

    logic                  req_wait_s;
    logic                  req_err_s;
    logic                  wait_hold_s;
    logic                  mem_wait_s;
    logic                  flush_s;
    logic [NUM_STAGES-1:0] stall_s;
    logic [NUM_STAGES-1:0] clr_s;

    // Decode the memory response against the current state.
    always_comb begin
        req_wait_s  = (state_q == ST_RUN) && bus.i_mem_req_en && (bus.i_mem_res_code == CODE_WAIT);
        req_err_s   = (state_q == ST_RUN) && bus.i_mem_req_en && (bus.i_mem_res_code == CODE_ERR);
        // An empty response while already waiting still means "not ready".
        wait_hold_s = (bus.i_mem_res_code == CODE_WAIT) || (bus.i_mem_res_code == CODE_NONE);
        mem_wait_s  = req_wait_s ||
                      ((state_q == ST_MEM_WAIT) && (bus.i_mem_res_code != CODE_DONE));
    end

    // State, timeout and fault registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_RUN;
            tmr_q   <= {TMR_W{1'b0}};
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic: memory wait tracking, timeout and error faults.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        if (!resetn) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_err_s) begin
                        state_d = ST_FAULT;
                    end else if (req_wait_s) begin
                        tmr_d   = TMR_ONE;
                        state_d = (TMR_ONE >= TMR_LIMIT) ? ST_FAULT : ST_MEM_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.i_mem_res_code == CODE_DONE) begin
                        state_d = ST_RUN;
                    end else if (bus.i_mem_res_code == CODE_ERR) begin
                        state_d = ST_FAULT;
                    end else begin
                        tmr_d   = tmr_q + TMR_ONE;
                        state_d = (tmr_d >= TMR_LIMIT) ? ST_FAULT : ST_MEM_WAIT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
        fault_d = (state_d == ST_FAULT);
    end

    // Stall/clear masks by priority: reset, fault, memory wait, branch, hazard.
    always_comb begin
        stall_s = ALL_ZERO;
        clr_s   = ALL_ZERO;
        flush_s = 1'b0;
        if (!aresetn || !resetn) begin
            clr_s = ALL_ONES;
        end else if (state_q == ST_FAULT) begin
            stall_s = ALL_ONES;
        end else if (mem_wait_s) begin
            // Younger stages freeze and ME takes a bubble; older stages drain.
            stall_s = STALL_MEM;
            clr_s   = CLR_MEM;
        end else if (bus.i_branch) begin
            // A taken branch squashes the wrong-path instructions, so any
            // concurrent load-use stall is moot.
            clr_s   = CLR_BR;
            flush_s = 1'b1;
        end else if (bus.i_load_hazard) begin
            stall_s = STALL_HAZ;
            clr_s   = CLR_HAZ;
        end else begin
            stall_s = ALL_ZERO;
            clr_s   = ALL_ZERO;
        end
    end

    // Saturating counter updates; a soft reset leaves the counters intact.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_len_d  = wait_len_q;
        if ((|stall_s) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        if (!resetn) begin
            wait_len_d = wait_len_q;
        end else if (req_wait_s) begin
            wait_len_d = CNT_ONE;
        end else if ((state_q == ST_MEM_WAIT) && wait_hold_s && (wait_len_q != CNT_MAX)) begin
            wait_len_d = wait_len_q + CNT_ONE;
        end else begin
            wait_len_d = wait_len_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
            wait_len_q  <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_len_q  <= wait_len_d;
        end
    end

    assign bus.o_stall     = stall_s;
    assign bus.o_clr       = clr_s;
    assign bus.o_fault     = fault_q;
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;
    assign bus.o_wait_len  = wait_len_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed test-plan sequences followed by random stimulus,
// all compared against a cycle-level reference model built from the controller's
// behavioural rules.
module tb_pipe_ctrl;

    localparam int N     = 5;
    localparam int HAZ   = 1;
    localparam int FD    = 2;
    localparam int ME    = 3;
    localparam int TMO   = 4;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int ALL   = (1 << N) - 1;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FAULT = 2;

    logic clk = 1'b0;
    logic aresetn;
    logic resetn;

    pipe_ctrl_if #(.NUM_STAGES(N), .MEM_CODE_W(2), .CNT_W(CW)) ifc ();

    pipe_ctrl #(
        .NUM_STAGES (N),
        .HAZ_STAGE  (HAZ),
        .FLUSH_DEPTH(FD),
        .ME_STAGE   (ME),
        .MEM_CODE_W (2),
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .resetn (resetn),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mode;
    int m_stalls;
    int m_flushes;
    int m_wait_len;
    int m_consec;

    logic [N-1:0] obs_stall;
    logic [N-1:0] obs_clr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    // One clock cycle: apply inputs at the falling edge, compare, advance the model.
    task automatic step(input bit br, input bit hz, input bit req, input int code,
                        input bit rn, input bit arn);
        int  es;
        int  ec;
        bit  waiting;
        bit  flush;
        ifc.i_branch       = br;
        ifc.i_load_hazard  = hz;
        ifc.i_mem_req_en   = req;
        ifc.i_mem_res_code = code[1:0];
        resetn             = rn;
        aresetn            = arn;
        if (!arn) begin
            m_mode     = M_RUN;
            m_stalls   = 0;
            m_flushes  = 0;
            m_wait_len = 0;
            m_consec   = 0;
        end
        #1;
        waiting = ((m_mode == M_RUN) && req && (code == 1)) ||
                  ((m_mode == M_WAIT) && (code != 2));
        es    = 0;
        ec    = 0;
        flush = 1'b0;
        if (!arn || !rn) begin
            ec = ALL;
        end else if (m_mode == M_FAULT) begin
            es = ALL;
        end else if (waiting) begin
            es = (1 << ME) - 1;
            ec = 1 << ME;
        end else if (br) begin
            ec    = ((1 << (FD + 1)) - 1) & ~1;
            flush = 1'b1;
        end else if (hz) begin
            es = (1 << (HAZ + 1)) - 1;
            ec = 1 << (HAZ + 1);
        end
        obs_stall = ifc.o_stall;
        obs_clr   = ifc.o_clr;
        check_eq("stall",     32'(ifc.o_stall),     es);
        check_eq("clr",       32'(ifc.o_clr),       ec);
        check_eq("fault",     32'(ifc.o_fault),     (m_mode == M_FAULT) ? 1 : 0);
        check_eq("stall_cnt", 32'(ifc.o_stall_cnt), m_stalls);
        check_eq("flush_cnt", 32'(ifc.o_flush_cnt), m_flushes);
        check_eq("wait_len",  32'(ifc.o_wait_len),  m_wait_len);
        if (arn) begin
            if (es != 0) m_stalls = sat_inc(m_stalls);
            if (flush)   m_flushes = sat_inc(m_flushes);
            if (!rn) begin
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (req && (code == 3)) begin
                    m_mode = M_FAULT;
                end else if (req && (code == 1)) begin
                    m_consec   = 1;
                    m_wait_len = 1;
                    m_mode     = (m_consec >= TMO) ? M_FAULT : M_WAIT;
                end
            end else if (m_mode == M_WAIT) begin
                if (code == 2) begin
                    m_mode = M_RUN;
                end else if (code == 3) begin
                    m_mode = M_FAULT;
                end else begin
                    m_consec   = m_consec + 1;
                    m_wait_len = sat_inc(m_wait_len);
                    if (m_consec >= TMO) m_mode = M_FAULT;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        aresetn            = 1'b0;
        resetn             = 1'b1;
        ifc.i_branch       = 1'b0;
        ifc.i_load_hazard  = 1'b0;
        ifc.i_mem_req_en   = 1'b0;
        ifc.i_mem_res_code = 2'd0;
        m_mode = M_RUN; m_stalls = 0; m_flushes = 0; m_wait_len = 0; m_consec = 0;
        @(negedge clk);

        // Reset then idle
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_rst_stall", 32'(obs_stall), 32'd0);
        check_eq("tp_rst_clr",   32'(obs_clr),   32'd0);

        // Memory wait of three cycles then DONE
        repeat (3) step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        check_eq("tp_wait_stall", 32'(obs_stall), 32'b00111);
        check_eq("tp_wait_clr",   32'(obs_clr),   32'b01000);
        step(1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1);
        check_eq("tp_done_stall", 32'(obs_stall),       32'd0);
        check_eq("tp_wait_len",   32'(ifc.o_wait_len),  32'd3);
        check_eq("tp_wait_scnt",  32'(ifc.o_stall_cnt), 32'd3);

        // Branch beats hazard, then hazard alone
        step(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_br_clr",   32'(obs_clr),   32'b00110);
        check_eq("tp_br_stall", 32'(obs_stall), 32'd0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_hz_stall", 32'(obs_stall),       32'b00011);
        check_eq("tp_hz_clr",   32'(obs_clr),         32'b00100);
        check_eq("tp_br_fcnt",  32'(ifc.o_flush_cnt), 32'd1);

        // Timeout into FAULT, then soft reset
        repeat (4) step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        check_eq("tp_tmo_fault", 32'(ifc.o_fault), 32'd1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_fault_stall", 32'(obs_stall), 32'b11111);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check_eq("tp_srst_clr",   32'(obs_clr),         32'b11111);
        check_eq("tp_srst_fault", 32'(ifc.o_fault),     32'd0);
        check_eq("tp_srst_scnt",  32'(ifc.o_stall_cnt), 32'd9);
        check_eq("tp_srst_fcnt",  32'(ifc.o_flush_cnt), 32'd1);

        // Error response, then branch ignored during a wait
        step(1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b1);
        check_eq("tp_err_fault", 32'(ifc.o_fault), 32'd1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        check_eq("tp_brwait_clr", 32'(obs_clr), 32'b01000);
        step(1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1);
        check_eq("tp_brwait_fcnt", 32'(ifc.o_flush_cnt), 32'd1);

        // Saturation, then asynchronous reset mid-wait
        repeat (20) step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_sat_scnt", 32'(ifc.o_stall_cnt), 32'd15);
        step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0);
        check_eq("tp_ares_scnt", 32'(ifc.o_stall_cnt), 32'd0);
        check_eq("tp_ares_wlen", 32'(ifc.o_wait_len),  32'd0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        check_eq("tp_ares_run", 32'(obs_stall), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 24) != 0),
                 1'($urandom_range(0, 79) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
